// File: rtl/branch_history_table.sv
// rtl/branch_history_table.sv - 2-bit saturating-counter branch direction predictor
// Power-up sweep seeds every entry weakly not-taken before queries and updates are accepted.
module branch_history_table #(
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              q_valid,
  input  logic [ADDR_W-1:0] q_pc,
  output logic              q_resp_valid,
  output logic              q_taken,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_mispredict,
  input  logic              jump_wrong,
  output logic              init_done,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [1:0]         tbl_q [DEPTH];
  logic               resp_valid_q;
  logic               taken_q;
  logic               init_done_q;
  logic [31:0]        stat_br_q;
  logic [31:0]        stat_mp_q;

  logic [IDX_W-1:0]   q_idx;
  logic [1:0]         upd_old;
  logic [1:0]         upd_d;
  logic               upd_en;
  logic [1:0]         q_ctr;
  logic [31:0]        stat_br_d;
  logic [31:0]        stat_mp_d;
  logic               unused_pc;

  assign q_idx     = q_pc[IDX_W+1:2];
  assign unused_pc = ^{q_pc[ADDR_W-1:IDX_W+2], q_pc[1:0]};
  assign upd_old   = tbl_q[upd_idx];
  assign upd_en    = rdy && (state_q == S_RUN) && upd_valid;

  always_comb begin
    upd_d = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'b11) upd_d = upd_old + 2'b01;
    end else begin
      if (upd_old != 2'b00) upd_d = upd_old - 2'b01;
    end
  end

  // A query to the index being updated this cycle sees the new counter value.
  assign q_ctr = (upd_en && (upd_idx == q_idx)) ? upd_d : tbl_q[q_idx];

  assign stat_br_d = (stat_br_q != 32'hFFFF_FFFF) ? stat_br_q + 32'd1 : stat_br_q;
  assign stat_mp_d = (upd_mispredict && (stat_mp_q != 32'hFFFF_FFFF)) ? stat_mp_q + 32'd1 : stat_mp_q;

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (state_q == S_INIT) begin
        tbl_q[ptr_q] <= 2'b01;
      end else if (upd_valid) begin
        tbl_q[upd_idx] <= upd_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_INIT;
      ptr_q        <= '0;
      resp_valid_q <= 1'b0;
      taken_q      <= 1'b0;
      init_done_q  <= 1'b0;
      stat_br_q    <= '0;
      stat_mp_q    <= '0;
    end else if (rdy) begin
      case (state_q)
        S_INIT: begin
          resp_valid_q <= 1'b0;
          taken_q      <= 1'b0;
          ptr_q        <= ptr_q + 1'b1;
          if (ptr_q == {IDX_W{1'b1}}) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        S_RUN: begin
          resp_valid_q <= q_valid && !jump_wrong;
          taken_q      <= q_valid && !jump_wrong && q_ctr[1];
          if (upd_valid) begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign q_resp_valid     = resp_valid_q;
  assign q_taken          = taken_q;
  assign init_done        = init_done_q;
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: doc/branch_history_table.md
BRANCH_HISTORY_TABLE -- requirements
Module: branch_history_table

Interface
REQ-001 Parameter: IDX_W, default 8, index width; the table holds 2^IDX_W entries.
REQ-002 Parameter: ADDR_W, default 32, PC width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low: reset takes effect at a rising clk edge while rst==0.
REQ-005 rdy  in  1  global enable; when 0, all state and outputs SHALL hold.
REQ-006 q_valid  in  1  IF requests a direction prediction this cycle.
REQ-007 q_pc  in  ADDR_W  PC of the queried branch; index = q_pc[IDX_W+1:2].
REQ-008 q_resp_valid  out  1  registered; q_taken is valid this cycle.
REQ-009 q_taken  out  1  predicted direction (1 = taken).
REQ-010 upd_valid  in  1  ROB commit feedback for one resolved conditional branch.
REQ-011 upd_idx  in  IDX_W  table index of the resolved branch.
REQ-012 upd_taken  in  1  actual outcome.
REQ-013 upd_mispredict  in  1  committed prediction was wrong; counted only.
REQ-014 jump_wrong  in  1  pipeline flush.
REQ-015 init_done  out  1  table initialised; queries and updates are accepted.
REQ-016 stat_branches  out  32  count of accepted updates.
REQ-017 stat_mispredicts  out  32  count of accepted updates with upd_mispredict==1.

Function
REQ-018 Each table entry SHALL be a 2-bit saturating counter; prediction = counter[1].
REQ-019 FSM states: INIT and RUN; reset SHALL force INIT with the sweep pointer at 0.
REQ-020 INIT: write 2'b01 to the entry at the sweep pointer each enabled cycle, then increment the pointer.
REQ-021 INIT: after writing entry 2^IDX_W-1, move to RUN; init_done rises on the cycle RUN is entered (2^IDX_W enabled cycles after reset release).
REQ-022 INIT: ignore q_valid and upd_valid; q_resp_valid=0; stats do not change.
REQ-023 RUN update: upd_valid==1 with upd_taken==1 increments the entry at upd_idx, saturating at 3.
REQ-024 RUN update: upd_valid==1 with upd_taken==0 decrements the entry at upd_idx, saturating at 0.
REQ-025 RUN query latency is 1 cycle: q_valid at edge N gives q_resp_valid=1 with q_taken after edge N; otherwise q_resp_valid=0.
REQ-026 Same-cycle query and update to the same index: q_taken SHALL reflect the post-update counter (bypass).
REQ-027 jump_wrong==1 at an edge SHALL force q_resp_valid=0 after that edge, even if q_valid==1.
REQ-028 jump_wrong SHALL NOT block a concurrent update; the update and its stats SHALL still apply.
REQ-029 Each accepted update increments stat_branches by 1; if upd_mispredict==1, it also increments stat_mispredicts by 1.
REQ-030 Both stat counters saturate at 32'hFFFFFFFF.
REQ-031 rdy==0: the FSM, sweep pointer, table, stats and outputs all hold; q_valid and upd_valid are ignored.

Reset
REQ-032 rst==0 at an edge (rdy is don't-care):
- q_resp_valid=0, q_taken=0, init_done=0;
- stat_branches=0, stat_mispredicts=0;
- FSM enters INIT with the sweep pointer at 0.
REQ-033 Reset during RUN or mid-INIT SHALL restart the full initialisation sweep.

Verification
REQ-034 Reset, IDX_W=8, rdy=1: init_done=0 for 255 cycles after release and rises at cycle 256; query pc=0x100 -> q_taken=0.
REQ-035 Saturation at idx 0x40: 4 taken updates, then query pc=0x100 -> q_taken=1 and counter=3; then 2 not-taken updates -> q_taken=0; 3 more not-taken -> counter=0.
REQ-036 Bypass: counter at 1; same cycle upd_valid, idx 0x40, taken=1, plus q_valid, pc=0x100 -> next cycle q_resp_valid=1, q_taken=1.
REQ-037 Flush: q_valid=1 together with jump_wrong=1 and upd_valid=1, upd_mispredict=1 -> q_resp_valid=0; stat_branches and stat_mispredicts each increase by 1.
REQ-038 Stall: rdy=0 for 10 cycles mid-INIT while upd_valid toggles -> init_done is delayed exactly 10 cycles; no stat change.
REQ-039 Reset mid-RUN after updates -> stats return to 0, init_done=0, and every entry reads back not-taken after the sweep.
